// File: rtl/conv_line_feeder.sv
// -----------------------------------------------------------------------------
// conv_line_feeder
//
// Producer side of the 3x3 convolution column interface. Takes a raster-order,
// single-channel pixel stream (one pixel per in_valid/in_ready handshake) and
// uses two line buffers to present vertically aligned column triples
// (top = row r-2, mid = row r-1, bot = row r) to the convolution core.
//
// Optional build macro:
//   BORDER_REPLICATE_EN - when defined, the first two rows of each frame also
//                         produce triples, with the missing rows replicated
//                         from the nearest available row. When undefined,
//                         only rows 2..IMG_HEIGHT-1 produce triples.
//
// Ports:
//   clk        clock
//   rst_n      synchronous, active-low reset
//   in_valid   in_pixel is valid
//   in_ready   feeder accepts in_pixel this cycle
//   in_pixel   raster-order input pixel
//   in_sof     start of frame, qualified by in_valid && in_ready
//   out_valid  column triple is valid
//   out_ready  downstream accepts the triple
//   out_top    pixel at (r-2, c)
//   out_mid    pixel at (r-1, c)
//   out_bot    pixel at (r, c)
//   out_col    column c of the triple
//   out_row    row r of the triple (row of out_bot)
//   out_eof    triple is the last one of the frame
// -----------------------------------------------------------------------------
module conv_line_feeder #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_top,
    output logic [PIXEL_WIDTH-1:0] out_mid,
    output logic [PIXEL_WIDTH-1:0] out_bot,
    output logic [CW-1:0]          out_col,
    output logic [RW-1:0]          out_row,
    output logic                   out_eof
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    localparam logic [0:0] ST_PRIME  = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Line buffers: line_a holds row r-1, line_b holds row r-2 (relative to
    // the row currently arriving). Contents are never reset; the PRIME rows
    // overwrite every entry before any of it is used.
    logic [PIXEL_WIDTH-1:0] line_a [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] line_b [IMG_WIDTH];

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [0:0]             state;

    logic                   acc;
    logic [CW-1:0]          pos_col;
    logic [RW-1:0]          pos_row;
    logic [0:0]             pos_state;
    logic [PIXEL_WIDTH-1:0] rd_a;
    logic [PIXEL_WIDTH-1:0] rd_b;
    logic                   at_row_end;
    logic                   at_prime_end;
    logic                   at_frame_end;

    logic                   emit;
    logic [PIXEL_WIDTH-1:0] cand_top;
    logic [PIXEL_WIDTH-1:0] cand_mid;
    logic [CW-1:0]          col_nxt;
    logic [RW-1:0]          row_nxt;
    logic [0:0]             state_nxt;

    // Single output register stage: we can take a pixel whenever the output
    // register is empty or is being drained this cycle.
    assign in_ready = out_ready || !out_valid;
    assign acc      = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) in PRIME, whatever the
    // counters say, so a partial frame is simply abandoned.
    assign pos_col   = in_sof ? '0 : col;
    assign pos_row   = in_sof ? '0 : row;
    assign pos_state = in_sof ? ST_PRIME : state;

    // Buffer reads use the pre-write contents; the writes below are
    // non-blocking, so the same-index read/write in one cycle is safe.
    assign rd_a = line_a[pos_col];
    assign rd_b = line_b[pos_col];

    assign at_row_end   = (pos_col == COL_LAST);
    assign at_prime_end = at_row_end && (pos_row == ROW_ONE);
    assign at_frame_end = at_row_end && (pos_row == ROW_LAST);

    always_comb begin
        col_nxt   = col;
        row_nxt   = row;
        state_nxt = state;
        emit      = 1'b0;
        cand_top  = rd_b;
        cand_mid  = rd_a;

        if (acc) begin
            if (at_row_end) begin
                col_nxt = '0;
                row_nxt = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_ONE;
            end else begin
                col_nxt = pos_col + COL_ONE;
                row_nxt = pos_row;
            end

            case (pos_state)
                ST_PRIME: begin
                    state_nxt = at_prime_end ? ST_STREAM : ST_PRIME;
`ifdef BORDER_REPLICATE_EN
                    // Missing rows above the frame replicate the nearest row.
                    emit = 1'b1;
                    if (pos_row == '0) begin
                        cand_top = in_pixel;
                        cand_mid = in_pixel;
                    end else begin
                        cand_top = rd_a;
                        cand_mid = rd_a;
                    end
`endif
                end
                default: begin
                    emit      = 1'b1;
                    state_nxt = at_frame_end ? ST_PRIME : ST_STREAM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            line_b[pos_col] <= rd_a;
            line_a[pos_col] <= in_pixel;
        end
    end

    // ---- accept -> output register boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            state     <= ST_PRIME;
            out_valid <= 1'b0;
            out_top   <= '0;
            out_mid   <= '0;
            out_bot   <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_eof   <= 1'b0;
        end else begin
            col   <= col_nxt;
            row   <= row_nxt;
            state <= state_nxt;
            if (emit) begin
                out_valid <= 1'b1;
                out_top   <= cand_top;
                out_mid   <= cand_mid;
                out_bot   <= in_pixel;
                out_col   <= pos_col;
                out_row   <= pos_row;
                out_eof   <= at_frame_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/conv_line_feeder.md
Name: conv_line_feeder

Overview:
Producer side of the 3x3 convolution column interface. It accepts a raster-order, single-channel pixel stream one pixel per handshake. Two internal line buffers turn that stream into vertically aligned column triples (top = row r-2, mid = row r-1, bot = row r), which are presented one per cycle to the convolution core's pix_top/pix_mid/pix_bot inputs. Handshakes are ready/valid on both sides, and frame and row position tags are attached to every output.

Parameters:
PIXEL_WIDTH, 8, bits per pixel.
IMG_WIDTH, 64, pixels per row (>= 3).
IMG_HEIGHT, 64, rows per frame (>= 3).
CW, $clog2(IMG_WIDTH), column counter width (derived, localparam).
RW, $clog2(IMG_HEIGHT), row counter width (derived, localparam).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  in_pixel is valid.
in_ready  out  1  feeder accepts in_pixel this cycle.
in_pixel  in  PIXEL_WIDTH  raster-order input pixel.
in_sof  in  1  start of frame; qualified by in_valid && in_ready.
out_valid  out  1  column triple is valid.
out_ready  in  1  downstream accepts the triple.
out_top  out  PIXEL_WIDTH  pixel at (r-2, c).
out_mid  out  PIXEL_WIDTH  pixel at (r-1, c).
out_bot  out  PIXEL_WIDTH  pixel at (r, c).
out_col  out  CW  column c of this triple.
out_row  out  RW  row r of this triple (row of out_bot).
out_eof  out  1  triple is the last one of the frame (r = IMG_HEIGHT-1, c = IMG_WIDTH-1).

Behaviour:
- Clock and reset: clk; reset rst_n, synchronous, active-low.
- Reset values: out_valid=0; out_top/mid/bot=0; out_col=0; out_row=0; out_eof=0; col and row counters=0; state=PRIME. in_ready=1 in the cycle after reset.
- Line buffer contents are not reset. Stale data is never emitted because PRIME refills both buffers.
- Accept condition: acc = in_valid && in_ready, where in_ready = out_ready || !out_valid. This is a single-stage pipeline and needs no skid buffer.
- On acc at column c:
  - lineB[c] <= lineA[c]; lineA[c] <= in_pixel.
  - Candidate triple = (lineB[c], lineA[c], in_pixel), read before the write.
  - Read-before-write at the same index in the same cycle is mandatory.
- Counters advance on acc:
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row wraps IMG_HEIGHT-1 -> 0.
- State machine:
  - PRIME (rows 0..1): pixels are stored and no triple is emitted. Leave PRIME for STREAM on acc of the pixel at row 1, col IMG_WIDTH-1.
  - STREAM (rows 2..IMG_HEIGHT-1): every acc loads the output registers with the triple, col, row and eof, and sets out_valid=1 on the next cycle. Latency is 1 cycle from acc to out_valid.
  - On acc of the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1): the emitted triple carries out_eof=1, counters wrap to (0,0), and the state returns to PRIME.
- Output hold: while out_valid && !out_ready, all out_* signals hold and in_ready=0.
- Output clear: when out_ready is high and no new STREAM acc occurs, out_valid falls to 0 the next cycle.
- in_sof resync:
  - An accepted pixel with in_sof=1 is treated as (0,0) regardless of the counters; state is forced to PRIME.
  - Any partial frame is abandoned. An already-registered output is still delivered normally.
- in_sof=1 at natural position (0,0) has no additional effect.
- Reset mid-frame: all of the above reset values apply; the next accepted pixel is (0,0).

Optional Feature:
Macro BORDER_REPLICATE_EN.
- Defined: PRIME rows also emit triples, with the missing rows replicated.
  - Row 0 emits (in_pixel, in_pixel, in_pixel).
  - Row 1 emits (lineA[c], lineA[c], in_pixel).
  - Output is IMG_HEIGHT rows per frame. out_row/out_col/out_eof are tagged identically to STREAM.
- Not defined: behaviour exactly as in Behaviour; output is IMG_HEIGHT-2 rows per frame.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*r + c, out_ready=1 unless stated.
- Reset: assert rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0; in_ready=1 after release.
- Prime/stream: feed pixels 0x00..0x13 -> out_valid stays 0. Feed 0x21 at (2,1) -> next cycle out_top=0x01, out_mid=0x11, out_bot=0x21, out_col=1, out_row=2.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> outputs stable and in_ready=0. Release -> all 8 stream triples arrive in order with none lost or duplicated.
- Frame wrap: feed 0x33 -> triple (0x13, 0x23, 0x33) with out_eof=1. Next frame's first 8 pixels produce no out_valid; its 0x20 yields (0x00, 0x10, 0x20).
- Resync: assert in_sof at frame position (2,2) with value 0x00 -> the next 7 pixels produce no output; the following pixel is tagged out_row=2, out_col=0.
- BORDER_REPLICATE_EN: first pixel 0x00 -> (0x00, 0x00, 0x00) row 0. Pixel 0x12 -> (0x02, 0x02, 0x12) row 1. 16 triples per frame.
